// File: rtl/alu_sequencer.sv
// alu_sequencer: keypad-driven two-operand calculator controller.
//
// It debounces the keypad encoder's hex code and accumulates operand A, an
// operation and operand B. On '=' it writes A to register 0 and B to
// register 1, lets the ALU settle for one cycle and then captures the
// result and the zero flag.
//
// Optional feature (compile-time macro ALU_SEQ_WRITEBACK_EN):
//   defined   - the CAPTURE state also writes alu_out to register 2.
//   undefined - register 2 is never written; each operation makes exactly
//               two register writes.
module alu_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    output logic       reg_we,
    output logic [1:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [1:0] reg_rd_a,
    output logic [1:0] reg_rd_b,
    output logic [1:0] alu_sel,
    output logic [7:0] result,
    output logic       zero,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        ENTER_B = 3'd1,
        WR_A    = 3'd2,
        WR_B    = 3'd3,
        EXEC    = 3'd4,
        CAPTURE = 3'd5,
        SHOW    = 3'd6
    } state_t;

    // Register-bank slots used by the sequence.
    localparam logic [1:0] ADDR_OPA = 2'd0;
    localparam logic [1:0] ADDR_OPB = 2'd1;
`ifdef ALU_SEQ_WRITEBACK_EN
    localparam logic [1:0] ADDR_RES = 2'd2;
`endif

    // The accept fires in the cycle the stable count would reach its target,
    // i.e. when the stored count is one short of it.
    localparam logic [7:0] DB_TARGET = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES - 1);

    // ------------------------------------------------------------------
    // Debounce state
    // ------------------------------------------------------------------
    logic [3:0] prev_code;
    logic       prev_valid;
    logic [7:0] stable_cnt;
    logic       released;
    logic       stable;
    logic       accept;

    // ------------------------------------------------------------------
    // Key classification (only meaningful when accept is high)
    // ------------------------------------------------------------------
    logic       key_is_digit;
    logic       key_is_op;
    logic       key_is_eq;
    logic       key_is_clr;
    logic [1:0] key_op;

    // ------------------------------------------------------------------
    // Sequencer state and operands
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_next;
    logic [7:0] op_a;
    logic [7:0] op_a_next;
    logic [7:0] op_b;
    logic [7:0] op_b_next;
    logic [1:0] op;
    logic [1:0] op_next;

    // A cycle is stable when the key was held in the previous cycle too and
    // the code did not change in between.
    assign stable = key_valid && prev_valid && (key_code == prev_code);
    assign accept = stable && released && (stable_cnt == DB_LAST);

    // Debounce: count stable cycles, fire once per press, re-arm on release.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            prev_code  <= 4'h0;
            prev_valid <= 1'b0;
            stable_cnt <= 8'd0;
            released   <= 1'b1;
        end else begin
            prev_code  <= key_code;
            prev_valid <= key_valid;

            if (stable) begin
                // Saturate so a long hold cannot wrap round to a new accept.
                if (stable_cnt != DB_TARGET) begin
                    stable_cnt <= stable_cnt + 8'd1;
                end
            end else begin
                stable_cnt <= 8'd0;
            end

            if (!key_valid) begin
                released <= 1'b1;
            end else if (accept) begin
                released <= 1'b0;
            end
        end
    end

    // Decode the accepted key into digit / operation / '=' / clear.
    always_comb begin
        key_is_digit = (key_code <= 4'h9);
        key_is_op    = (key_code >= 4'hA) && (key_code <= 4'hD);
        key_is_eq    = (key_code == 4'hE);
        key_is_clr   = (key_code == 4'hF);
        // 0xA..0xD map to 0..3: adding 2 to the low bits wraps modulo 4.
        key_op       = key_code[1:0] + 2'd2;
    end

    // Next-state, operand update and datapath-control decode.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case statement leaves one unassigned and infers a latch.
        state_next  = state;
        op_a_next   = op_a;
        op_b_next   = op_b;
        op_next     = op;

        reg_we      = 1'b0;
        reg_wr_addr = ADDR_OPA;
        reg_wr_data = 8'h00;
        reg_rd_a    = 2'd0;
        reg_rd_b    = 2'd0;
        alu_sel     = 2'd0;
        busy        = 1'b0;

        case (state)
            ENTER_A: begin
                if (accept) begin
                    if (key_is_digit) begin
                        op_a_next = {op_a[3:0], key_code};
                    end else if (key_is_op) begin
                        op_next    = key_op;
                        op_b_next  = 8'h00;
                        state_next = ENTER_B;
                    end else if (key_is_clr) begin
                        op_a_next  = 8'h00;
                        op_b_next  = 8'h00;
                        op_next    = 2'd0;
                        state_next = ENTER_A;
                    end
                    // '=' without a pending operation is ignored.
                end
            end

            ENTER_B: begin
                if (accept) begin
                    if (key_is_digit) begin
                        op_b_next = {op_b[3:0], key_code};
                    end else if (key_is_op) begin
                        op_next = key_op;
                    end else if (key_is_eq) begin
                        state_next = WR_A;
                    end else if (key_is_clr) begin
                        op_a_next  = 8'h00;
                        op_b_next  = 8'h00;
                        op_next    = 2'd0;
                        state_next = ENTER_A;
                    end
                end
            end

            WR_A: begin
                busy        = 1'b1;
                reg_we      = 1'b1;
                reg_wr_addr = ADDR_OPA;
                reg_wr_data = op_a;
                state_next  = WR_B;
            end

            WR_B: begin
                busy        = 1'b1;
                reg_we      = 1'b1;
                reg_wr_addr = ADDR_OPB;
                reg_wr_data = op_b;
                state_next  = EXEC;
            end

            EXEC: begin
                // One settle cycle for the register-bank read and the ALU.
                busy       = 1'b1;
                reg_rd_a   = ADDR_OPA;
                reg_rd_b   = ADDR_OPB;
                alu_sel    = op;
                state_next = CAPTURE;
            end

            CAPTURE: begin
                // Read addresses and select stay put while the result is taken.
                busy       = 1'b1;
                reg_rd_a   = ADDR_OPA;
                reg_rd_b   = ADDR_OPB;
                alu_sel    = op;
`ifdef ALU_SEQ_WRITEBACK_EN
                reg_we      = 1'b1;
                reg_wr_addr = ADDR_RES;
                reg_wr_data = alu_out;
`endif
                state_next = SHOW;
            end

            SHOW: begin
                if (accept) begin
                    if (key_is_digit) begin
                        // A digit starts a fresh calculation.
                        op_a_next  = {4'h0, key_code};
                        op_b_next  = 8'h00;
                        state_next = ENTER_A;
                    end else if (key_is_op) begin
                        // Chaining: the shown result becomes operand A.
                        op_a_next  = result;
                        op_next    = key_op;
                        op_b_next  = 8'h00;
                        state_next = ENTER_B;
                    end else if (key_is_clr) begin
                        op_a_next  = 8'h00;
                        op_b_next  = 8'h00;
                        op_next    = 2'd0;
                        state_next = ENTER_A;
                    end
                end
            end

            default: begin
                state_next = ENTER_A;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ENTER_A;
            op_a   <= 8'h00;
            op_b   <= 8'h00;
            op     <= 2'd0;
            result <= 8'h00;
            zero   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            op_a  <= op_a_next;
            op_b  <= op_b_next;
            op    <= op_next;

            // Capturing on the CAPTURE edge makes result and done appear
            // together in the following cycle.
            done <= (state == CAPTURE);
            if (state == CAPTURE) begin
                result <= alu_out;
                zero   <= alu_zero;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a small register-bank + ALU
// model (0:add 1:sub 2:and 3:or). Directed key sequences with hand-computed
// expected results. Build with ALU_SEQ_WRITEBACK_EN defined to check the
// register-2 writeback variant.
module tb_alu_sequencer;

    localparam int DB   = 4;       // debounce cycles used for this bench
    localparam int HOLD = DB + 2;  // long enough for one accept
    localparam int REL  = 3;       // release gap between presses

    // State encodings as fixed by the design's enum.
    localparam logic [31:0] ST_ENTER_A = 32'd0;
    localparam logic [31:0] ST_ENTER_B = 32'd1;
    localparam logic [31:0] ST_SHOW    = 32'd6;

`ifdef ALU_SEQ_WRITEBACK_EN
    localparam int WE_PER_OP = 3;
`else
    localparam int WE_PER_OP = 2;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       reg_we;
    logic [1:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [1:0] reg_rd_a;
    logic [1:0] reg_rd_b;
    logic [1:0] alu_sel;
    logic [7:0] result;
    logic       zero;
    logic       busy;
    logic       done;

    alu_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .reg_we      (reg_we),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_a    (reg_rd_a),
        .reg_rd_b    (reg_rd_b),
        .alu_sel     (alu_sel),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Register bank + ALU model.
    logic [7:0] rb [4];
    logic [7:0] alu_a;
    logic [7:0] alu_b;

    always @(posedge clk) begin
        if (reg_we) rb[reg_wr_addr] <= reg_wr_data;
    end

    always_comb begin
        alu_a = rb[reg_rd_a];
        alu_b = rb[reg_rd_b];
        case (alu_sel)
            2'd0:    alu_out = alu_a + alu_b;
            2'd1:    alu_out = alu_a - alu_b;
            2'd2:    alu_out = alu_a & alu_b;
            default: alu_out = alu_a | alu_b;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    // Output monitor, sampled on the falling edge.
    int         cyc = 0;
    int         we_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         busy_rise_cyc = 0;
    int         busy_cnt = 0;
    logic       busy_prev = 1'b0;
    logic [1:0] we_addr_log [16];
    logic [7:0] we_data_log [16];
    logic [7:0] done_result = 8'h00;
    logic       done_zero = 1'b0;

    always @(negedge clk) begin
        cyc       <= cyc + 1;
        busy_prev <= busy;
        if (reg_we) begin
            we_addr_log[we_cnt & 15] <= reg_wr_addr;
            we_data_log[we_cnt & 15] <= reg_wr_data;
            we_cnt <= we_cnt + 1;
        end
        if (done) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            done_result <= result;
            done_zero   <= zero;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (busy && !busy_prev) busy_rise_cyc <= cyc;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] c);
        @(negedge clk);
        key_valid = v;
        key_code  = c;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 4'h0);
    endtask

    task automatic press(input logic [3:0] c);
        repeat (HOLD) step(1'b1, c);
        idle(REL);
    endtask

    // Press '=' and check the whole write/execute/capture sequence.
    task automatic run_equals(input string tag, input logic [7:0] exp_a,
                              input logic [7:0] exp_b, input logic [7:0] exp_res,
                              input logic exp_z);
        int we_base;
        int done_base;
        int busy_base;
        we_base   = we_cnt;
        done_base = done_cnt;
        busy_base = busy_cnt;
        press(4'hE);
        idle(8);
        check({tag, "_we_count"},  32'(we_cnt - we_base), 32'(WE_PER_OP));
        check({tag, "_wr0_addr"},  32'(we_addr_log[we_base & 15]), 32'd0);
        check({tag, "_wr0_data"},  32'(we_data_log[we_base & 15]), 32'(exp_a));
        check({tag, "_wr1_addr"},  32'(we_addr_log[(we_base + 1) & 15]), 32'd1);
        check({tag, "_wr1_data"},  32'(we_data_log[(we_base + 1) & 15]), 32'(exp_b));
`ifdef ALU_SEQ_WRITEBACK_EN
        check({tag, "_wr2_addr"},  32'(we_addr_log[(we_base + 2) & 15]), 32'd2);
        check({tag, "_wr2_data"},  32'(we_data_log[(we_base + 2) & 15]), 32'(exp_res));
`endif
        check({tag, "_done_count"}, 32'(done_cnt - done_base), 32'd1);
        check({tag, "_latency"},   32'(done_cyc - busy_rise_cyc), 32'd4);
        check({tag, "_busy_len"},  32'(busy_cnt - busy_base), 32'd4);
        check({tag, "_result"},    32'(done_result), 32'(exp_res));
        check({tag, "_zero"},      32'(done_zero), 32'(exp_z));
        check({tag, "_state"},     32'(dut.state), ST_SHOW);
    endtask

    initial begin
        int   we_base;
        int   we_extra;
        logic found;

        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("reset_outputs",
              32'({reg_we, reg_wr_addr, reg_wr_data, reg_rd_a, reg_rd_b,
                   alu_sel, result, zero, busy, done}), 32'd0);
        check("reset_state", 32'(dut.state), ST_ENTER_A);
        reset = 1'b0;
        idle(2);

        // 12 + 03 = 15.
        press(4'h1);
        press(4'h2);
        check("opa_entry", 32'(dut.op_a), 32'h12);
        press(4'hA);
        check("op_to_enter_b", 32'(dut.state), ST_ENTER_B);
        press(4'h0);
        press(4'h3);
        check("opb_entry", 32'(dut.op_b), 32'h03);
        run_equals("add", 8'h12, 8'h03, 8'h15, 1'b0);
        check("result_held", 32'(result), 32'h15);

        // A press one cycle short of the debounce target is ignored.
        repeat (DB - 1) step(1'b1, 4'h7);
        idle(REL);
        check("short_press_state", 32'(dut.state), ST_SHOW);
        check("short_press_opa", 32'(dut.op_a), 32'h12);

        // Chaining: 15 - 5 = 10; the digit is held for three debounce periods.
        press(4'hB);
        check("chain_opa", 32'(dut.op_a), 32'h15);
        check("chain_state", 32'(dut.state), ST_ENTER_B);
        repeat (3 * DB) step(1'b1, 4'h5);
        idle(REL);
        check("long_hold_one_accept", 32'(dut.op_b), 32'h05);
        run_equals("sub", 8'h15, 8'h05, 8'h10, 1'b0);

        // Digit in SHOW starts fresh: 3 - 3 = 0 sets zero.
        press(4'h3);
        check("show_digit_opa", 32'(dut.op_a), 32'h03);
        check("show_digit_state", 32'(dut.state), ST_ENTER_A);
        press(4'hB);
        press(4'h3);
        run_equals("zero", 8'h03, 8'h03, 8'h00, 1'b1);

        // Clear in ENTER_B: back to ENTER_A, operands zero, no writes.
        we_base = we_cnt;
        press(4'h4);
        press(4'hA);
        press(4'h6);
        press(4'hF);
        idle(2);
        check("clear_state", 32'(dut.state), ST_ENTER_A);
        check("clear_operands", 32'({dut.op_a, dut.op_b, dut.op}), 32'd0);
        check("clear_no_we", 32'(we_cnt - we_base), 32'd0);
        check("clear_keeps_zero", 32'({result, zero}), 32'h001);

        // '=' in ENTER_A is ignored.
        we_base = we_cnt;
        press(4'h2);
        press(4'hE);
        idle(6);
        check("eq_in_enter_a_state", 32'(dut.state), ST_ENTER_A);
        check("eq_in_enter_a_no_we", 32'(we_cnt - we_base), 32'd0);

        // Reset while in WR_B abandons the operation.
        press(4'hA);
        press(4'h1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 4'hE);
            if (reg_we === 1'b1 && reg_wr_addr === 2'd1) found = 1'b1;
        end
        check("reach_wr_b", 32'(found), 32'd1);
        reset = 1'b1;
        step(1'b0, 4'h0);
        check("rst_mid_we", 32'(reg_we), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_state", 32'(dut.state), ST_ENTER_A);
        check("rst_mid_result", 32'({result, zero, done}), 32'd0);
        reset = 1'b0;
        we_extra = 0;
        repeat (6) begin
            step(1'b0, 4'h0);
            if (reg_we === 1'b1) we_extra++;
        end
        check("rst_mid_no_more_we", 32'(we_extra), 32'd0);

        // Recovery after reset: 03 AND 06 = 02.
        press(4'h3);
        press(4'hC);
        press(4'h0);
        press(4'h6);
        run_equals("and", 8'h03, 8'h06, 8'h02, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Keypad-driven controller that sequences the register bank and ALU as a two-operand calculator. It consumes the keypad encoder's hex code, debounces it and accumulates two 8-bit operands and an operation. On '=' it writes the operands into the register bank, executes the ALU and latches the result. It sits between the keypad encoder and the register-bank/ALU datapath, and drives the register bank's write and read address ports.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a key; legal range 1..255.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `key_valid` input 1: encoder reports a key held.
- `key_code` input 4: encoder hex code, meaningful while `key_valid`=1.
- `alu_out` input 8: ALU result, combinational from the register-bank read ports.
- `alu_zero` input 1: ALU zero flag.
- `reg_we` output 1: register-bank write enable.
- `reg_wr_addr` output 2: register-bank write address.
- `reg_wr_data` output 8: register-bank write data.
- `reg_rd_a` output 2: register-bank port A read address.
- `reg_rd_b` output 2: register-bank port B read address.
- `alu_sel` output 2: ALU operation select.
- `result` output 8: last captured ALU result.
- `zero` output 1: zero flag captured with `result`.
- `busy` output 1: high in the WR_A, WR_B, EXEC and CAPTURE states; keys are ignored while high.
- `done` output 1: one-cycle pulse when `result` updates.

## Operation
- Key map:
  - 0x0–0x9: digit.
  - 0xA–0xD: operation; `alu_sel` = code − 0xA (0xA→0, 0xB→1, 0xC→2, 0xD→3).
  - 0xE: '='.
  - 0xF: clear.
- Debounce:
  - An internal counter counts cycles with `key_valid`=1 and `key_code` equal to its previous-cycle value.
  - The counter resets on a code change or when `key_valid`=0.
  - One accept event fires when the count reaches `DEBOUNCE_CYCLES`.
  - The next accept requires `key_valid`=0 for at least one cycle (release).
- Digit entry: operand <= {operand[3:0], digit}, so the last two digits typed are held.
- FSM states: ENTER_A, ENTER_B, WR_A, WR_B, EXEC, CAPTURE, SHOW.
- ENTER_A:
  - Digit: updates opA.
  - Operation key: latches op, clears opB, goes to ENTER_B.
  - '=': ignored.
- ENTER_B:
  - Digit: updates opB.
  - Operation key: replaces op.
  - '=': goes to WR_A.
- WR_A: `reg_we`=1, `reg_wr_addr`=0, `reg_wr_data`=opA; goes to WR_B.
- WR_B: `reg_we`=1, `reg_wr_addr`=1, `reg_wr_data`=opB; goes to EXEC.
- EXEC:
  - `reg_rd_a`=0, `reg_rd_b`=1, `alu_sel`=op. These values are held through CAPTURE.
  - One settle cycle; goes to CAPTURE.
- CAPTURE: `result`<=`alu_out`, `zero`<=`alu_zero`, `done`=1; goes to SHOW.
- SHOW:
  - Digit: opA <= {4'h0, digit}, opB <= 0, goes to ENTER_A.
  - Operation key (chaining): opA <= `result`, op latched, opB <= 0, goes to ENTER_B.
  - '=': ignored.
- Clear (0xF) in ENTER_A, ENTER_B or SHOW: opA, opB and op <= 0, goes to ENTER_A. `result` and `zero` are kept.
- Keys accepted while `busy`=1 are discarded, not queued.
- `reg_we`=0 in every state not listed above as asserting it.

## Timing
- Reset values:
  - State ENTER_A.
  - opA, opB, op = 0.
  - All outputs 0: `reg_we`, `reg_wr_addr`, `reg_wr_data`, `reg_rd_a`, `reg_rd_b`, `alu_sel`, `result`, `zero`, `busy`, `done`.
  - Debounce counter 0, release flag set (ready to accept).
- Reset mid-sequence: abandons the operation; no further register writes after the reset cycle.
- Key acceptance latency: the accept fires in the cycle where the stable count reaches `DEBOUNCE_CYCLES`. The state/operand update is visible on the next edge.
- '=' to `done`: the '=' accept edge enters WR_A. `done` pulses exactly 4 cycles later (WR_A, WR_B, EXEC, CAPTURE), and `result` is valid in the same cycle as `done`.
- All outputs are registered or decoded from registered state; there is no combinational path from `key_*` to outputs.
- Operand arithmetic is modulo 8 bits; the ALU carry is not used.

## Configuration
- `ALU_SEQ_WRITEBACK_EN`:
  - Defined: CAPTURE also asserts `reg_we`=1, `reg_wr_addr`=2, `reg_wr_data`=`alu_out`, storing each result in register 2.
  - Undefined: `reg_we`=0 in CAPTURE; register 2 is never written by this block.

## Test plan
- Digits 1,2 → op 0xA → digits 0,3 → '=' with ALU model add:
  - WR_A writes 0x12 to addr 0; WR_B writes 0x03 to addr 1.
  - `result`=0x15, `zero`=0, `done` one cycle, 4 cycles after the '=' accept.
- Key held for `DEBOUNCE_CYCLES`−1 cycles then released → no accept, state unchanged.
- Key held for 3×`DEBOUNCE_CYCLES` cycles → exactly one accept.
- SHOW with `result`=0x15, op key 0xB, digit 5, '=' (ALU model subtract) → opA=0x15, `result`=0x10.
- Clear pressed in ENTER_B → state ENTER_A, operands 0, no `reg_we` pulse.
- Reset asserted during WR_B → next cycle `reg_we`=0, `busy`=0, state ENTER_A.
- With `ALU_SEQ_WRITEBACK_EN` defined → CAPTURE writes the result to addr 2. With it undefined → exactly 2 `reg_we` pulses per operation.
